// File: rtl/series_datapath.sv
// Datapath for the iterative series evaluator: X/T/R/C/RC registers, a saturating
// fixed-point multiply/add ALU, and the registered termination flag lt.
module series_datapath #(
  parameter int          W    = 16,
  parameter int          FRAC = 12,
  parameter int          CW   = 4,
  parameter int unsigned EPS  = 32'h0010
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x_in,
  input  logic          initt,
  input  logic          initr,
  input  logic          initc,
  input  logic          ld_x,
  input  logic          ld_t,
  input  logic          ld_r,
  input  logic          ld_c,
  input  logic          cnt,
  input  logic          s2,
  input  logic          s1,
  input  logic          s0,
  input  logic          mode,
  output logic          lt,
  output logic [W-1:0]  result,
  output logic [CW-1:0] c_out
);

  localparam logic [W-1:0] MAXV  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] EPS_W = W'(EPS);
  localparam logic [W-1:0] ONE   = W'(1) << FRAC;
  localparam logic signed [2*W-1:0] MAXP = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MINP = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [W-1:0] r_x, r_t, r_r, r_rc;
  logic [CW-1:0]       r_c;
  logic                r_lt;

  // round(2^FRAC / k), saturated; index 0 maps to max positive
  function automatic logic [W-1:0] rom_val(input int k);
    longint q;
    if (k == 0) return MAXV;
    q = ((longint'(1) << FRAC) + longint'(k / 2)) / longint'(k);
    if (q > longint'(MAXV)) return MAXV;
    return W'(q);
  endfunction

  logic [W-1:0] w_rom [2**CW];
  for (genvar k = 0; k < 2**CW; k++) begin : g_rom
    assign w_rom[k] = rom_val(k);
  end

  // multiplier path
  logic signed [W-1:0]   w_ma, w_mb;
  logic signed [2*W-1:0] w_prod, w_sh;
  logic [W-1:0]          w_mul;

  always_comb begin
    w_ma = r_t;
    w_mb = r_x;
    case ({s1, s0})
      2'b00: begin w_ma = r_t; w_mb = r_x;  end
      2'b01: begin w_ma = r_t; w_mb = r_rc; end
      2'b10: begin w_ma = r_x; w_mb = r_x;  end
      default: begin w_ma = r_r; w_mb = r_x; end
    endcase
  end

  assign w_prod = w_ma * w_mb;
  assign w_sh   = w_prod >>> FRAC;   // arithmetic shift floors toward -inf
  assign w_mul  = (w_sh > MAXP) ? MAXV : (w_sh < MINP) ? MINV : w_sh[W-1:0];

  // adder path
  logic signed [W-1:0] w_ap, w_aq;
  logic signed [W:0]   w_sum;
  logic [W-1:0]        w_add, w_alu;

  always_comb begin
    w_ap = r_r;
    w_aq = r_t;
    case ({s1, s0})
      2'b00:   begin w_ap = r_r; w_aq = r_t; end
      2'b01:   begin w_ap = r_t; w_aq = r_x; end
      default: begin w_ap = r_r; w_aq = r_x; end
    endcase
  end

  assign w_sum = mode ? ({w_ap[W-1], w_ap} - {w_aq[W-1], w_aq})
                      : ({w_ap[W-1], w_ap} + {w_aq[W-1], w_aq});
  assign w_add = (w_sum[W] == w_sum[W-1]) ? w_sum[W-1:0] : (w_sum[W] ? MINV : MAXV);
  assign w_alu = !s2 ? w_mul : ({s1, s0} == 2'b11) ? r_t : w_add;

  // |T| with the most-negative value pinned to max so it is never "small"
  logic [W-1:0] w_abs;
  logic         w_lt_nxt;
  always_comb begin
    if (r_t == MINV)   w_abs = MAXV;
    else if (r_t[W-1]) w_abs = -r_t;
    else               w_abs = r_t;
  end
  assign w_lt_nxt = (w_abs < EPS_W) || (r_c == {CW{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x  <= '0;
      r_t  <= '0;
      r_r  <= '0;
      r_c  <= '0;
      r_rc <= '0;
      r_lt <= 1'b0;
    end else begin
      if (ld_x)       r_x <= x_in;
      if (initt)      r_t <= ONE;
      else if (ld_t)  r_t <= w_alu;
      if (initr)      r_r <= '0;
      else if (ld_r)  r_r <= w_alu;
      if (initc)      r_c <= CW'(1);
      else if (cnt)   r_c <= r_c + CW'(1);
      if (ld_c)       r_rc <= w_rom[r_c];
      r_lt <= w_lt_nxt;
    end
  end

  assign lt     = r_lt;
  assign result = r_r;
  assign c_out  = r_c;

endmodule

// File: tb/tb_series_datapath.sv
// Directed test-plan sequence plus random strobes, all checked cycle by cycle
// against an integer-arithmetic model of the datapath.
module tb_series_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x_in = '0;
  logic        initt = 0, initr = 0, initc = 0, ld_x = 0, ld_t = 0, ld_r = 0, ld_c = 0, cnt = 0;
  logic        s2 = 0, s1 = 0, s0 = 0, mode = 0;
  logic        lt;
  logic [15:0] result;
  logic [3:0]  c_out;

  series_datapath dut (
    .clk(clk), .rst(rst), .x_in(x_in),
    .initt(initt), .initr(initr), .initc(initc),
    .ld_x(ld_x), .ld_t(ld_t), .ld_r(ld_r), .ld_c(ld_c), .cnt(cnt),
    .s2(s2), .s1(s1), .s0(s0), .mode(mode),
    .lt(lt), .result(result), .c_out(c_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int mx = 0, mt = 0, mr = 0, mc = 0, mrc = 0, mlt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int fdiv4096(input longint p);
    longint q;
    q = p / 4096;
    if (p < 0 && (p % 4096) != 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int rom_m(input int k);
    if (k == 0) return 32767;
    return sat(longint'($rtoi(4096.0 / k + 0.5)));
  endfunction

  function automatic int alu_m();
    int a, b;
    case ({s2, s1, s0})
      3'b000: return sat(fdiv4096(longint'(mt) * mx));
      3'b001: return sat(fdiv4096(longint'(mt) * mrc));
      3'b010: return sat(fdiv4096(longint'(mx) * mx));
      3'b011: return sat(fdiv4096(longint'(mr) * mx));
      3'b111: return mt;
      default: begin
        a = (s1 == 0 && s0 == 0) ? mr : (s0 ? mt : mr);
        b = (s1 == 0 && s0 == 0) ? mt : mx;
        return sat(mode ? longint'(a) - b : longint'(a) + b);
      end
    endcase
  endfunction

  task automatic idle();
    {initt, initr, initc, ld_x, ld_t, ld_r, ld_c, cnt} = '0;
  endtask

  task automatic step();
    int a, nt, nr, nc, nx, nrc, nlt, abs_t;
    a     = alu_m();
    abs_t = (mt < 0) ? -mt : mt;
    nlt   = ((abs_t < 16) && (mt != -32768)) || (mc == 15);
    nt    = initt ? 4096 : (ld_t ? a : mt);
    nr    = initr ? 0 : (ld_r ? a : mr);
    nc    = initc ? 1 : (cnt ? (mc + 1) % 16 : mc);
    nx    = ld_x ? int'($signed(x_in)) : mx;
    nrc   = ld_c ? rom_m(mc) : mrc;
    @(posedge clk);
    mt = nt; mr = nr; mc = nc; mx = nx; mrc = nrc; mlt = nlt;
    #1;
    chk("result", 32'(result), 32'(mr & 16'hFFFF));
    chk("c_out",  32'(c_out),  32'(mc));
    chk("lt",     32'(lt),     32'(mlt));
    idle();
  endtask

  task automatic sel(input logic [2:0] s, input logic m);
    {s2, s1, s0} = s;
    mode = m;
  endtask

  // observe T by passing it into R
  task automatic peek_t(input string tag, input logic [15:0] exp);
    sel(3'b111, 1'b0); ld_r = 1; step();
    chk(tag, 32'(result), 32'(exp));
  endtask

  task automatic load_x(input logic [15:0] v);
    x_in = v; ld_x = 1; step();
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    mt = 0; mr = 0; mc = 0; mx = 0; mrc = 0; mlt = 0;
    chk({tag, "_result"}, 32'(result), 32'h0);
    chk({tag, "_c_out"},  32'(c_out),  32'h0);
    chk({tag, "_lt"},     32'(lt),     32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    #1;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_c_out",  32'(c_out),  32'h0);
    chk("rst_lt",     32'(lt),     32'h0);
    @(negedge clk);
    rst = 1'b1;

    // init
    initt = 1; initr = 1; initc = 1; step();
    chk("init_r", 32'(result), 32'h0);
    chk("init_c", 32'(c_out), 32'h1);
    peek_t("init_t", 16'h1000);

    // multiply by 0.5 twice
    load_x(16'h0800);
    sel(3'b000, 0); ld_t = 1; step();
    peek_t("mul1", 16'h0800);
    sel(3'b000, 0); ld_t = 1; step();
    peek_t("mul2", 16'h0400);

    // reciprocal of 3
    initc = 1; step();
    cnt = 1; step();
    cnt = 1; step();
    ld_c = 1; step();
    chk("c_is_3", 32'(c_out), 32'h3);
    initt = 1; step();
    sel(3'b001, 0); ld_t = 1; step();
    peek_t("recip3", 16'h0555);

    // add / subtract / saturate
    initt = 1; step();
    peek_t("r_1000", 16'h1000);
    sel(3'b000, 0); ld_t = 1; step();
    sel(3'b100, 0); ld_r = 1; step();
    chk("add", 32'(result), 32'h1800);
    sel(3'b100, 1); ld_r = 1; step();
    chk("sub", 32'(result), 32'h1000);
    load_x(16'h7000);
    initr = 1; step();
    sel(3'b110, 0); ld_r = 1; step();
    chk("r_7000", 32'(result), 32'h7000);
    initt = 1; step();
    load_x(16'h2000);
    sel(3'b000, 0); ld_t = 1; step();
    sel(3'b100, 0); ld_r = 1; step();
    chk("add_sat", 32'(result), 32'h7FFF);

    // termination on small T
    initt = 1; step();
    load_x(16'h000F);
    sel(3'b000, 0); ld_t = 1; step();
    step();
    chk("lt_small", 32'(lt), 32'h1);
    load_x(16'h0010);
    initt = 1; step();
    sel(3'b000, 0); ld_t = 1; step();
    step();
    chk("lt_eps", 32'(lt), 32'h0);

    // termination on C at max
    initc = 1; step();
    for (int i = 0; i < 14; i++) begin cnt = 1; step(); end
    chk("c_15", 32'(c_out), 32'hF);
    step();
    chk("lt_cmax", 32'(lt), 32'h1);

    // priority
    initc = 1; step();
    for (int i = 0; i < 4; i++) begin cnt = 1; step(); end
    chk("c_5", 32'(c_out), 32'h5);
    initc = 1; cnt = 1; step();
    chk("prio_c", 32'(c_out), 32'h1);
    sel(3'b000, 0); initt = 1; ld_t = 1; step();
    peek_t("prio_t", 16'h1000);

    // random traffic with a mid-run reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) async_reset("midrst");
      x_in  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x_in = 16'($urandom_range(0, 32)) - 16'd16;
      initt = ($urandom_range(0, 9) == 0);
      initr = ($urandom_range(0, 11) == 0);
      initc = ($urandom_range(0, 11) == 0);
      ld_x  = ($urandom_range(0, 3) == 0);
      ld_t  = ($urandom_range(0, 2) == 0);
      ld_r  = ($urandom_range(0, 2) == 0);
      ld_c  = ($urandom_range(0, 3) == 0);
      cnt   = ($urandom_range(0, 2) == 0);
      {s2, s1, s0} = 3'($urandom);
      mode  = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/series_datapath.md
# series_datapath

Datapath stage for the iterative series evaluator. It sits directly downstream of `controller` and consumes its init, load, count and select strobes. It holds the operand X, the running term T, the accumulated result R and the term index C. It computes T·X, T·(1/C) and R±T in signed fixed point, and returns the registered termination flag `lt` to the controller.

## Interface
- `W`, 16: data width, signed two's complement.
- `FRAC`, 12: fractional bits (Q3.12 at default).
- `CW`, 4: counter width; C ranges 0..2^CW−1.
- `EPS`, 16'h0010: termination threshold on |T|.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `x_in`  in  W: operand, captured on `ld_x`.
- `initt`, `initr`, `initc`  in  1 each: initialise T, R and C.
- `ld_x`, `ld_t`, `ld_r`, `ld_c`  in  1 each: load X, T, R and the reciprocal register RC.
- `cnt`  in  1: increment C.
- `s2`, `s1`, `s0`  in  1 each: ALU path and operand select.
- `mode`  in  1: 0 = add, 1 = subtract (adder path only).
- `lt`  out  1: termination flag, registered.
- `result`  out  W: the R register.
- `c_out`  out  CW: the C register.

## Operation
- Registers:
  - X, T and R are W bits wide.
  - C is CW bits wide.
  - RC is W bits wide and holds the registered reciprocal of C.
- Reset (`rst`=0, asynchronous): X, T, R, C and RC are 0, and `lt` is 0. `result` is 0 and `c_out` is 0.
- Initialisation values:
  - `initt`: T ← 1.0, i.e. 1<<FRAC.
  - `initr`: R ← 0.
  - `initc`: C ← 1.
- Load and count:
  - `ld_x`: X ← `x_in`.
  - `ld_t`: T ← alu.
  - `ld_r`: R ← alu.
  - `cnt`: C ← C+1, wrapping modulo 2^CW.
  - `ld_c`: RC ← rom[C], where rom[k] = round(2^FRAC / k) saturated to W bits, and rom[0] = max positive.
- Priority for a register with simultaneous strobes: init beats load/count. `initt` beats `ld_t`, `initr` beats `ld_r`, `initc` beats `cnt`.
- Unrelated strobes in the same cycle all take effect.
- ALU is combinational from current register values.
- Multiplier path, s2=0; operands selected by {s1,s0}:
  - 00: T·X
  - 01: T·RC
  - 10: X·X
  - 11: R·X
- Multiplier arithmetic:
  - The full 2W signed product is arithmetically shifted right by FRAC, rounding toward −∞.
  - The shifted product is then saturated to the W range [−2^(W−1), 2^(W−1)−1].
- Adder path, s2=1; result selected by {s1,s0}:
  - 00: R±T
  - 01: T±X
  - 10: R±X
  - 11: pass T
- Adder arithmetic:
  - `mode` selects + or −; `mode` is ignored for pass-T.
  - The W+1-bit result is saturated to W.
- `lt` is a register updated every cycle: lt ← (|T| < EPS) || (C == 2^CW−1).
  - |T| uses the current T. The |−2^(W−1)| case saturates to max and therefore never counts as small.
- Strobes are level-sampled at each edge; there are no handshakes and no internal state machine. Sequencing is owned by the controller.

## Timing
- All register updates take effect on the rising edge at which the strobe is sampled high.
- ALU latency is 0 cycles: the value is visible in the same cycle as the select change and written at the next edge.
- `ld_c` latency: RC reflects the C value present at the `ld_c` edge. For RC of the post-increment index, assert `cnt` one cycle before `ld_c`.
- `lt` latency: one cycle after the T or C change that causes it.
  - The controller must not sample `lt` in the cycle immediately after `ld_t`/`initt`; it must wait one further edge.
- C wrap: `cnt` at C = 2^CW−1 gives C = 0. `lt` is already 1 at that C value, so the controller must stop before the wrap.
- Reset mid-iteration clears all state immediately and asynchronously. Release is synchronous to `clk`: no update occurs on the edge coinciding with deassertion unless `rst` is already 1 before that edge.
- Post-reset: T=0 gives `lt`=1 one cycle after reset release. This is expected; the controller reasserts `initt` before it waits on `lt`.

## Test plan
1. Reset and init:
   - Assert `rst`=0 mid-run → all outputs 0 immediately.
   - Release, then pulse `initt`/`initr`/`initc` → T=0x1000, `result`=0, `c_out`=1.
2. Multiply: X=0x0800 (0.5), T=0x1000, {s2,s1,s0}=000, pulse `ld_t` → T=0x0800. Repeat → T=0x0400.
3. Reciprocal:
   - Sequence `cnt`, `cnt`, `ld_c` from C=1 → C=3, RC=0x0555.
   - Then sel=001, `ld_t` with T=0x1000 → T=0x0555.
4. Add, subtract and saturation (sel=100, `ld_r`):
   - R=0x1000, T=0x0800, `mode`=0 → R=0x1800.
   - `mode`=1 → R=0x1000.
   - R=0x7000, T=0x2000, `mode`=0 → R=0x7FFF.
5. Termination:
   - T loaded to 0x000F → `lt`=1 one cycle after the load edge.
   - T=0x0010 → `lt`=0.
   - C driven to 15 via `cnt` → `lt`=1 regardless of T.
6. Priority: `initc`+`cnt` in the same cycle at C=5 → C=1. `initt`+`ld_t` in the same cycle → T=0x1000.
